// File: rtl/csa5_pkg.sv
// rtl/csa5_pkg.sv - shared types and constants for the csa5 bit-serial five-operand adder
package csa5_pkg;

    localparam int NUM_OPS = 5;
    localparam int CNT_W   = 3;
    localparam int CARRY_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/popcount5.sv
// rtl/popcount5.sv - combinational population count of one five-bit operand column
module popcount5
    import csa5_pkg::*;
(
    input  logic [NUM_OPS-1:0] bits_in,
    output logic [CNT_W-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            count = count + CNT_W'(bits_in[i]);
        end
    end

endmodule

// File: rtl/csa5_sequencer.sv
// rtl/csa5_sequencer.sv - column-serial sum of five operands; CSA5_SKIP_EN enables early termination
module csa5_sequencer
    import csa5_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH+2:0]         out_sum,
    output logic                     busy
);

    localparam int K_W = $clog2(WIDTH);

    state_e                     state_q, state_d;
    logic [NUM_OPS*WIDTH-1:0]   ops_q, ops_d;
    logic [CARRY_W-1:0]         carry_q, carry_d;
    logic [K_W-1:0]             k_q, k_d;
    logic [WIDTH-1:0]           sum_q, sum_d;
    logic [WIDTH+2:0]           out_sum_q, out_sum_d;

    logic [NUM_OPS-1:0]         col_bits;
    logic [CNT_W-1:0]           col_cnt;
    logic [CARRY_W:0]           acc;

    always_comb begin
        for (int i = 0; i < NUM_OPS; i++) begin
            col_bits[i] = ops_q[i*WIDTH];
        end
    end

    popcount5 u_popcount5 (
        .bits_in (col_bits),
        .count   (col_cnt)
    );

    // carry never exceeds 4, so the 4-bit accumulator tops out at 9
    assign acc = {1'b0, carry_q} + {1'b0, col_cnt};

    always_comb begin
        state_d   = state_q;
        ops_d     = ops_q;
        carry_d   = carry_q;
        k_d       = k_q;
        sum_d     = sum_q;
        out_sum_d = out_sum_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = COUNT;
                    ops_d   = in_ops;
                    carry_d = '0;
                    k_d     = '0;
                    sum_d   = '0;
                end
            end
            COUNT: begin
`ifdef CSA5_SKIP_EN
                // nothing left to add: the cleared upper sum bits are already correct
                if (carry_q == '0 && ops_q == '0) begin
                    state_d   = DONE;
                    out_sum_d = {carry_q, sum_q};
                end else
`endif
                begin
                    sum_d[k_q] = acc[0];
                    carry_d    = acc[CARRY_W:1];
                    for (int i = 0; i < NUM_OPS; i++) begin
                        ops_d[i*WIDTH +: WIDTH] = {1'b0, ops_q[i*WIDTH+1 +: WIDTH-1]};
                    end
                    k_d = k_q + K_W'(1);
                    if (k_q == K_W'(WIDTH - 1)) begin
                        state_d   = DONE;
                        out_sum_d = {acc[CARRY_W:1], sum_d};
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ops_q     <= '0;
            carry_q   <= '0;
            k_q       <= '0;
            sum_q     <= '0;
            out_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            ops_q     <= ops_d;
            carry_q   <= carry_d;
            k_q       <= k_d;
            sum_q     <= sum_d;
            out_sum_q <= out_sum_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == COUNT) || (state_q == DONE);
    assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_csa5_sequencer.sv
// tb/tb_csa5_sequencer.sv - scoreboard bench for csa5_sequencer and popcount5
module tb_csa5_sequencer;

    localparam int W = 8;

    typedef struct {
        int unsigned sum;
        int          lat;
        int          e0;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [5*W-1:0]   in_ops;
    logic             out_valid;
    logic             out_ready;
    logic [W+2:0]     out_sum;
    logic             busy;

    logic [4:0]       pc_in;
    logic [2:0]       pc_out;

    exp_t             q[$];
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_err = 0;
    bit               seen = 1'b0;
    bit               rand_rdy = 1'b0;

    csa5_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ops    (in_ops),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    popcount5 u_pc (
        .bits_in (pc_in),
        .count   (pc_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input int unsigned total);
`ifdef CSA5_SKIP_EN
        for (int k = 0; k < W; k++) begin
            if (total < (32'd1 << k)) return k + 1;
        end
        return W;
`else
        return W;
`endif
    endfunction

    function automatic logic [5*W-1:0] make_ops(input int unsigned a, b, c, d, e);
        int unsigned v[5];
        logic [5*W-1:0] r;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e;
        for (int i = 0; i < 5; i++) r[i*W +: W] = v[i][W-1:0];
        return r;
    endfunction

    function automatic int unsigned ops_total(input logic [5*W-1:0] ops);
        int unsigned t = 0;
        for (int i = 0; i < 5; i++) t += ops[i*W +: W];
        return t;
    endfunction

    task automatic send(input logic [5*W-1:0] ops);
        exp_t e;
        in_ops   = ops;
        in_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (in_ready) begin
                e.sum = ops_total(ops);
                e.lat = exp_lat(e.sum);
                e.e0  = cyc + 1;
                q.push_back(e);
                @(posedge clk);
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("send_timeout", in_ready, 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 2000; n++) begin
            if (q.size() == 0) return;
            @(negedge clk);
        end
        check_eq("drain_timeout", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check_eq("unexpected_out", out_valid, 0);
            end else begin
                if (!seen) begin
                    check_eq("latency", cyc - q[0].e0, q[0].lat);
                    check_eq("sum_first", out_sum, q[0].sum);
                    seen = 1'b1;
                end
                if (out_ready) begin
                    check_eq("sum_accept", out_sum, q[0].sum);
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned stall_sum;
        logic [5*W-1:0] ops;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ops    = '0;

        for (int p = 0; p < 32; p++) begin
            pc_in = 5'(p);
            #1;
            check_eq("popcount5", pc_out, $countones(pc_in));
        end

        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_out_sum", out_sum, 0);
        rst_n = 1'b1;
        @(negedge clk);

        out_ready = 1'b1;
        send(make_ops(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF));
        wait_idle();
        send(make_ops(1, 2, 3, 4, 5));
        wait_idle();
        send(make_ops(0, 0, 0, 0, 0));
        wait_idle();

        // hold result in DONE while a second set is offered and must be ignored
        out_ready = 1'b0;
        ops = make_ops(8'hAA, 8'h55, 8'hF0, 8'h0F, 8'h81);
        stall_sum = ops_total(ops);
        send(ops);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            in_ops   = make_ops(7, 7, 7, 7, 7);
            in_valid = 1'b1;
            check_eq("stall_hold", out_sum, stall_sum);
            check_eq("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);

        send(make_ops(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF));
        repeat (3) @(negedge clk);
        check_eq("count_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_out_sum", out_sum, 0);
        q.delete();
        seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check_eq("abort_no_out", out_valid, 0);
        end
        send(make_ops(8'h10, 8'h10, 8'h10, 8'h10, 8'h10));
        wait_idle();

        rand_rdy = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            logic [5*W-1:0] r;
            for (int i = 0; i < 5; i++) begin
                r[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 15) == 0) r = '0;
            send(r);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        rand_rdy = 1'b0;
        check_eq("final_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
